// File: rtl/us_pipeline_pkg.sv
// Shared ultrasound back-end definitions: default widths, line/frame geometry and
// the scan-line read FSM encoding used by the scan assembler and scan conversion.
package us_pipeline_pkg;

    localparam int unsigned COMP_WIDTH_DEF = 24;
    localparam int unsigned PIX_WIDTH_DEF  = 8;
    localparam int unsigned SAMPLES_DEF    = 64;
    localparam int unsigned NUM_LINES_DEF  = 128;
    localparam int unsigned DECIM_DEF      = 1;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_FETCH   = 2'd1,
        RD_PRESENT = 2'd2
    } rd_state_e;

    // Counter width that stays legal (>=1 bit) even when the count range is 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Ping-pong line storage: two banks of SAMPLES words, one write port and one
// registered read port, each addressed by {bank select, sample pointer}.
module line_bank_ram #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned SAMPLES = 64
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [$clog2(SAMPLES)-1:0] wr_ptr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       rd_sel,
    input  logic [$clog2(SAMPLES)-1:0] rd_ptr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem [2][SAMPLES];

    // NOTE: storage and read register carry no reset; contents are meaningless until a
    // line is written and bank_full tracking upstream never exposes stale words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_ptr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_sel][rd_ptr];
        end
    end

endmodule

// File: rtl/scanline_assembler.sv
// Decimates compressed samples into a ping-pong line buffer and streams each full
// line out as pixels with first/last/line/frame markers, back-pressuring the input.
module scanline_assembler
    import us_pipeline_pkg::*;
#(
    parameter int unsigned COMP_WIDTH = COMP_WIDTH_DEF,
    parameter int unsigned PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int unsigned SAMPLES    = SAMPLES_DEF,
    parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
    parameter int unsigned DECIM      = DECIM_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COMP_WIDTH-1:0]        comp_in,
    input  logic                         comp_valid,
    output logic                         comp_ready,
    output logic [PIX_WIDTH-1:0]         pix_out,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic                         pix_first,
    output logic                         pix_last,
    output logic [$clog2(NUM_LINES)-1:0] line_idx,
    output logic                         frame_done
);

    localparam int unsigned PTR_W  = idx_width(SAMPLES);
    localparam int unsigned LINE_W = idx_width(NUM_LINES);
    localparam int unsigned DCNT_W = idx_width(DECIM);

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(SAMPLES - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
    localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DECIM - 1);

    rd_state_e         state_q, state_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [LINE_W-1:0] line_idx_q, line_idx_d;
    logic              frame_done_q, frame_done_d;

    logic                  accept;
    logic                  store;
    logic                  line_written;
    logic                  line_released;
    logic                  rd_en;
    logic [COMP_WIDTH-1:0] rd_data;
    logic                  unused_rd_bits;

    // ---------------- write side ----------------
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        comp_ready   = reset & ~bank_full_q[wsel_q];
        accept       = comp_valid & comp_ready;
        store        = accept & (dcnt_q == '0);
        line_written = store & (wptr_q == LAST_PTR);

        dcnt_d = dcnt_q;
        wptr_d = wptr_q;
        wsel_d = wsel_q;
        if (accept) begin
            dcnt_d = (dcnt_q == LAST_DCNT) ? '0 : dcnt_q + 1'b1;
        end
        if (store) begin
            if (line_written) begin
                wptr_d = '0;
                wsel_d = ~wsel_q;
            end else begin
                wptr_d = wptr_q + 1'b1;
            end
        end
    end

    // ---------------- read FSM ----------------
    always_comb begin
        state_d       = state_q;
        rsel_d        = rsel_q;
        rptr_d        = rptr_q;
        line_idx_d    = line_idx_q;
        frame_done_d  = 1'b0;
        rd_en         = 1'b0;
        pix_valid     = 1'b0;
        pix_first     = 1'b0;
        pix_last      = 1'b0;
        line_released = 1'b0;

        unique case (state_q)
            RD_IDLE: begin
                if (bank_full_q[rsel_q]) begin
                    state_d = RD_FETCH;
                end
            end
            RD_FETCH: begin
                rd_en   = 1'b1;
                state_d = RD_PRESENT;
            end
            RD_PRESENT: begin
                pix_valid = 1'b1;
                pix_first = (rptr_q == '0);
                pix_last  = (rptr_q == LAST_PTR);
                if (pix_ready) begin
                    if (pix_last) begin
                        line_released = 1'b1;
                        rsel_d        = ~rsel_q;
                        rptr_d        = '0;
                        state_d       = RD_IDLE;
                        if (line_idx_q == LAST_LINE) begin
                            line_idx_d   = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            line_idx_d = line_idx_q + 1'b1;
                        end
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        state_d = RD_FETCH;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // Completion and release always target opposite banks, so both may apply at once.
    always_comb begin
        bank_full_d = bank_full_q;
        if (line_written) begin
            bank_full_d[wsel_q] = 1'b1;
        end
        if (line_released) begin
            bank_full_d[rsel_q] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RD_IDLE;
            bank_full_q  <= 2'b00;
            wsel_q       <= 1'b0;
            rsel_q       <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            dcnt_q       <= '0;
            line_idx_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_full_q  <= bank_full_d;
            wsel_q       <= wsel_d;
            rsel_q       <= rsel_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            dcnt_q       <= dcnt_d;
            line_idx_q   <= line_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    line_bank_ram #(
        .WIDTH   (COMP_WIDTH),
        .SAMPLES (SAMPLES)
    ) u_line_bank_ram (
        .clk     (clk),
        .wr_en   (store),
        .wr_sel  (wsel_q),
        .wr_ptr  (wptr_q),
        .wr_data (comp_in),
        .rd_en   (rd_en),
        .rd_sel  (rsel_q),
        .rd_ptr  (rptr_q),
        .rd_data (rd_data)
    );

    // Only the top PIX_WIDTH bits of a stored sample become the pixel.
    assign unused_rd_bits = ^rd_data;
    assign pix_out        = rd_data[COMP_WIDTH-1 -: PIX_WIDTH];
    assign line_idx       = line_idx_q;
    assign frame_done     = frame_done_q;

    a_no_overwrite: assert property (@(posedge clk) disable iff (!reset)
        store |-> !bank_full_q[wsel_q]);
    a_banks_distinct: assert property (@(posedge clk) disable iff (!reset)
        (line_written && line_released) |-> (wsel_q != rsel_q));

endmodule
